// File: rtl/mix_round_checker.sv
// mix_round_checker: consumer-side checker for the 8x32-bit mixing round.
// The first accepted vector seeds a working state; the block then recomputes
// one full round serially (one word update per clock, 128 clocks) and compares
// the result with the next accepted vector, reporting pass/fail, the lowest
// differing word and saturating pass/fail counters.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous soft clear (to IDLE, counters zeroed); beats all inputs
//   in_valid   producer has a vector on in_data
//   in_ready   block can accept a vector (registered state decode)
//   in_data    8 words, word i at [32i+31:32i]
//   chk_valid  one-cycle pulse: compare result valid
//   chk_pass   result of the last compare, held
//   fail_word  lowest differing word index of the last compare (0 on pass)
//   pass_count saturating count of passing compares
//   fail_count saturating count of failing compares
module mix_round_checker #(
    parameter bit          RESYNC = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [255:0]     in_data,
    output logic             chk_valid,
    output logic             chk_pass,
    output logic [2:0]       fail_word,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count
);

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned N_WORDS = 8;
    localparam int unsigned STEP_W  = 7;

    localparam logic [STEP_W-1:0] LAST_STEP = 7'd127;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPUTE,
        ST_WAIT
    } state_t;

    state_t state;
    state_t state_next;

    logic [STEP_W-1:0]              step;
    logic [N_WORDS-1:0][WORD_W-1:0] o;
    logic [N_WORDS-1:0][WORD_W-1:0] in_words;

    logic accept;
    logic load_in;
    logic do_update;
    logic chk_fire;

    logic [2:0]        idx;
    logic [2:0]        phase;
    logic [WORD_W-1:0] cur;
    logic [WORD_W-1:0] w_m1;
    logic [WORD_W-1:0] w_m2;
    logic [WORD_W-1:0] w_p1;
    logic [WORD_W-1:0] w_p2;
    logic [WORD_W-1:0] w_p3;
    logic [WORD_W-1:0] w_p4;
    logic [WORD_W-1:0] w_p5;
    logic [WORD_W-1:0] upd;
    logic [WORD_W-1:0] m1;
    logic [WORD_W-1:0] c1;
    logic [WORD_W-1:0] m2;
    logic [WORD_W-1:0] c2;

    logic [N_WORDS-1:0] diff;
    logic               cmp_pass;
    logic [2:0]         cmp_idx;

    assign in_words = in_data;
    assign accept   = in_valid & in_ready;

    // step[2:0] is the word index, step[5:3] the phase A..H (phase mod 8)
    assign idx   = step[2:0];
    assign phase = step[5:3];

    // Neighbour taps; 3-bit arithmetic gives the mod-8 wrap for free
    assign cur  = o[idx];
    assign w_m1 = o[idx - 3'd1];
    assign w_m2 = o[idx - 3'd2];
    assign w_p1 = o[idx + 3'd1];
    assign w_p2 = o[idx + 3'd2];
    assign w_p3 = o[idx + 3'd3];
    assign w_p4 = o[idx + 3'd4];
    assign w_p5 = o[idx + 3'd5];

    // Per-word multiply/add constants for phases G and H
    always_comb begin : round_consts
        m1 = 32'd2;
        c1 = 32'd3;
        m2 = 32'd2;
        c2 = 32'd0;
        case (idx)
            3'd0: begin m1 = 32'd2;  c1 = 32'd3;  m2 = 32'd2;  c2 = 32'd0;   end
            3'd1: begin m1 = 32'd3;  c1 = 32'd5;  m2 = 32'd3;  c2 = 32'd1;   end
            3'd2: begin m1 = 32'd5;  c1 = 32'd7;  m2 = 32'd3;  c2 = 32'd8;   end
            3'd3: begin m1 = 32'd7;  c1 = 32'd11; m2 = 32'd3;  c2 = 32'd27;  end
            3'd4: begin m1 = 32'd11; c1 = 32'd13; m2 = 32'd5;  c2 = 32'd64;  end
            3'd5: begin m1 = 32'd13; c1 = 32'd17; m2 = 32'd13; c2 = 32'd125; end
            3'd6: begin m1 = 32'd17; c1 = 32'd19; m2 = 32'd35; c2 = 32'd216; end
            3'd7: begin m1 = 32'd19; c1 = 32'd23; m2 = 32'd87; c2 = 32'd343; end
            default: ;
        endcase
    end

    // Single-word update for the current phase
    always_comb begin : word_update
        upd = cur;
        case (phase)
            3'd0: upd = cur + 32'(idx);
            3'd1: upd = cur + w_m1;
            3'd2: upd = cur + w_p1 - w_p5;
            3'd3: upd = cur ^ (w_p3 << 16);
            3'd4: upd = cur - (w_p2 >> 17) + (w_p4 >> 12);
            3'd5: upd = cur + w_m1 - w_m2;
            3'd6: upd = cur * m1 + c1;
            3'd7: upd = cur * m2 + c2;
            default: ;
        endcase
    end

    // Word-by-word compare; lowest differing index wins
    always_comb begin : compare
        cmp_idx = 3'd0;
        for (int i = 0; i < int'(N_WORDS); i++) begin
            diff[i] = (in_words[i] != o[i]);
        end
        for (int i = int'(N_WORDS) - 1; i >= 0; i--) begin
            if (diff[i]) begin
                cmp_idx = 3'(i);
            end
        end
        cmp_pass = ~|diff;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode
    always_comb begin : fsm_next
        state_next = state;
        load_in    = 1'b0;
        do_update  = 1'b0;
        chk_fire   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    load_in    = 1'b1;
                    state_next = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                do_update = 1'b1;
                if (step == LAST_STEP) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (accept) begin
                    chk_fire   = 1'b1;
                    load_in    = RESYNC;
                    state_next = ST_COMPUTE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (clr) begin
            state_next = ST_IDLE;
            load_in    = 1'b0;
            do_update  = 1'b0;
            chk_fire   = 1'b0;
        end
    end

    // Working state and step counter; step wraps 127 -> 0 on the last update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step <= '0;
            o    <= '0;
        end else begin
            if (clr) begin
                step <= '0;
            end else if (do_update) begin
                step <= step + 7'd1;
            end
            if (load_in) begin
                o <= in_words;
            end else if (do_update) begin
                o[idx] <= upd;
            end
        end
    end

    // Registered outputs: handshake, compare result, saturating counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready   <= 1'b1;
            chk_valid  <= 1'b0;
            chk_pass   <= 1'b0;
            fail_word  <= 3'd0;
            pass_count <= '0;
            fail_count <= '0;
        end else begin
            in_ready  <= (state_next != ST_COMPUTE);
            chk_valid <= chk_fire;
            if (chk_fire) begin
                chk_pass  <= cmp_pass;
                fail_word <= cmp_idx;
            end
            if (clr) begin
                pass_count <= '0;
                fail_count <= '0;
            end else if (chk_fire) begin
                if (cmp_pass) begin
                    if (pass_count != CNT_MAX) begin
                        pass_count <= pass_count + CNT_W'(1);
                    end
                end else begin
                    if (fail_count != CNT_MAX) begin
                        fail_count <= fail_count + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mix_round_checker.sv
// Testbench for mix_round_checker. Two instances share all inputs: dut_a
// (RESYNC=1, 16-bit counters) and dut_b (RESYNC=0, 2-bit counters). A
// reference model follows the handshake, predicts each compare and pushes the
// expectation to a queue; a negedge monitor pops and checks it.
module tb_mix_round_checker;

    typedef logic [7:0][31:0] vec_t;

    typedef struct {
        int         cyc;
        bit         pass_a;
        logic [2:0] fw_a;
        int         pc_a;
        int         fc_a;
        bit         pass_b;
        logic [2:0] fw_b;
        int         pc_b;
        int         fc_b;
    } sb_t;

    localparam logic [31:0] M1 [8] = '{32'd2, 32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19};
    localparam logic [31:0] C1 [8] = '{32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19, 32'd23};
    localparam logic [31:0] M2 [8] = '{32'd2, 32'd3, 32'd3, 32'd3, 32'd5, 32'd13, 32'd35, 32'd87};
    localparam logic [31:0] C2 [8] = '{32'd0, 32'd1, 32'd8, 32'd27, 32'd64, 32'd125, 32'd216, 32'd343};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clr;
    logic         in_valid;
    logic [255:0] in_data;

    logic        in_ready_a, chk_valid_a, chk_pass_a;
    logic [2:0]  fail_word_a;
    logic [15:0] pass_count_a, fail_count_a;
    logic        in_ready_b, chk_valid_b, chk_pass_b;
    logic [2:0]  fail_word_b;
    logic [1:0]  pass_count_b, fail_count_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mix_round_checker #(.RESYNC(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .in_ready(in_ready_a), .in_data(in_data), .chk_valid(chk_valid_a),
        .chk_pass(chk_pass_a), .fail_word(fail_word_a),
        .pass_count(pass_count_a), .fail_count(fail_count_a)
    );

    mix_round_checker #(.RESYNC(1'b0), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .in_ready(in_ready_b), .in_data(in_data), .chk_valid(chk_valid_b),
        .chk_pass(chk_pass_b), .fail_word(fail_word_b),
        .pass_count(pass_count_b), .fail_count(fail_count_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Software model of one full round
    function automatic vec_t mix_round(input vec_t s);
        logic [31:0] w [8];
        vec_t r;
        for (int i = 0; i < 8; i++) w[i] = s[i];
        for (int ph = 0; ph < 16; ph++) begin
            for (int i = 0; i < 8; i++) begin
                case (ph % 8)
                    0: w[i] = w[i] + 32'(i);
                    1: w[i] = w[i] + w[(i + 7) % 8];
                    2: w[i] = w[i] + w[(i + 1) % 8] - w[(i + 5) % 8];
                    3: w[i] = w[i] ^ (w[(i + 3) % 8] << 16);
                    4: w[i] = w[i] - (w[(i + 2) % 8] >> 17) + (w[(i + 4) % 8] >> 12);
                    5: w[i] = w[i] + w[(i + 7) % 8] - w[(i + 6) % 8];
                    6: w[i] = w[i] * M1[i] + C1[i];
                    default: w[i] = w[i] * M2[i] + C2[i];
                endcase
            end
        end
        for (int i = 0; i < 8; i++) r[i] = w[i];
        return r;
    endfunction

    function automatic logic [2:0] first_diff(input vec_t x, input vec_t y);
        logic [2:0] fw = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (x[i] != y[i]) fw = 3'(i);
        end
        return fw;
    endfunction

    // Reference model: tracks readiness and expected working states
    int   cyc = 0;
    int   m_busy = 0;
    int   acc_cnt = 0;
    int   last_acc_cyc = 0;
    bit   m_seeded = 1'b0;
    vec_t m_a = '0;
    vec_t m_b = '0;
    int   pc_a = 0, fc_a = 0, pc_b = 0, fc_b = 0;
    sb_t  sb[$];
    sb_t  e_new;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_seeded = 1'b0;
            m_busy   = 0;
            pc_a = 0; fc_a = 0; pc_b = 0; fc_b = 0;
            sb.delete();
        end else begin
            cyc++;
            if (clr) begin
                m_seeded = 1'b0;
                m_busy   = 0;
                pc_a = 0; fc_a = 0; pc_b = 0; fc_b = 0;
            end else if (in_valid && m_busy == 0) begin
                acc_cnt++;
                last_acc_cyc = cyc;
                if (!m_seeded) begin
                    m_a      = mix_round(in_data);
                    m_b      = m_a;
                    m_seeded = 1'b1;
                end else begin
                    e_new.cyc    = cyc;
                    e_new.pass_a = (in_data == m_a);
                    e_new.fw_a   = first_diff(in_data, m_a);
                    e_new.pass_b = (in_data == m_b);
                    e_new.fw_b   = first_diff(in_data, m_b);
                    if (e_new.pass_a) pc_a = (pc_a < 65535) ? pc_a + 1 : pc_a;
                    else              fc_a = (fc_a < 65535) ? fc_a + 1 : fc_a;
                    if (e_new.pass_b) pc_b = (pc_b < 3) ? pc_b + 1 : pc_b;
                    else              fc_b = (fc_b < 3) ? fc_b + 1 : fc_b;
                    e_new.pc_a = pc_a; e_new.fc_a = fc_a;
                    e_new.pc_b = pc_b; e_new.fc_b = fc_b;
                    sb.push_back(e_new);
                    m_a = mix_round(in_data);
                    m_b = mix_round(m_b);
                end
                m_busy = 128;
            end else if (m_busy > 0) begin
                m_busy--;
            end
        end
    end

    // Monitor: handshake every cycle, compare results when chk_valid is due
    int  chk_cnt = 0;
    int  last_chk_cyc = 0;
    int  chain_prev = -1;
    bit  chain_on = 1'b0;
    bit  mon_exp_cv;
    sb_t mon_e;

    always @(negedge clk) begin
        mon_exp_cv = (sb.size() > 0) && (sb[0].cyc == cyc);
        check_eq("in_ready_a", 64'(in_ready_a), 64'(m_busy == 0));
        check_eq("in_ready_b", 64'(in_ready_b), 64'(m_busy == 0));
        check_eq("chk_valid_a", 64'(chk_valid_a), 64'(mon_exp_cv));
        check_eq("chk_valid_b", 64'(chk_valid_b), 64'(mon_exp_cv));
        if (mon_exp_cv) begin
            mon_e = sb.pop_front();
            check_eq("chk_pass_a", 64'(chk_pass_a), 64'(mon_e.pass_a));
            check_eq("fail_word_a", 64'(fail_word_a), 64'(mon_e.fw_a));
            check_eq("pass_count_a", 64'(pass_count_a), 64'(mon_e.pc_a));
            check_eq("fail_count_a", 64'(fail_count_a), 64'(mon_e.fc_a));
            check_eq("chk_pass_b", 64'(chk_pass_b), 64'(mon_e.pass_b));
            check_eq("fail_word_b", 64'(fail_word_b), 64'(mon_e.fw_b));
            check_eq("pass_count_b", 64'(pass_count_b), 64'(mon_e.pc_b));
            check_eq("fail_count_b", 64'(fail_count_b), 64'(mon_e.fc_b));
            if (chain_on && chain_prev >= 0) begin
                check_eq("chain_gap", 64'(cyc - chain_prev), 64'd129);
            end
            chain_prev   = cyc;
            chk_cnt++;
            last_chk_cyc = cyc;
        end
    end

    task automatic send_vec(input vec_t v, input bit hold);
        int start;
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        start    = acc_cnt;
        n        = 0;
        while (acc_cnt == start && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("accepted", 64'(acc_cnt - start), 64'd1);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check_eq("drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    vec_t seed0, exp1, bad, exp2, v, f, g;
    int   seed_cyc, c0, n;

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready_a), 64'd1);
        check_eq("rst_chk_valid", 64'(chk_valid_a), 64'd0);
        check_eq("rst_pass_count", 64'(pass_count_a), 64'd0);
        check_eq("rst_fail_count", 64'(fail_count_a), 64'd0);
        rst_n = 1'b1;

        // Seed 0..7 followed by the model round output
        for (int i = 0; i < 8; i++) seed0[i] = 32'(i);
        exp1 = mix_round(seed0);
        send_vec(seed0, 1'b0);
        seed_cyc = last_acc_cyc;
        send_vec(exp1, 1'b0);
        drain();
        check_eq("seed_to_chk", 64'(last_chk_cyc - seed_cyc), 64'd129);
        check_eq("t1_pass", 64'(chk_pass_a), 64'd1);
        check_eq("t1_fail_word", 64'(fail_word_a), 64'd0);
        check_eq("t1_pass_count", 64'(pass_count_a), 64'd1);

        // clr during COMPUTE, then a single-bit error in word 3
        pulse_clr();
        check_eq("clr_pass_count", 64'(pass_count_a), 64'd0);
        check_eq("clr_in_ready", 64'(in_ready_a), 64'd1);
        send_vec(seed0, 1'b0);
        bad = exp1;
        bad[3][0] = ~bad[3][0];
        send_vec(bad, 1'b0);
        drain();
        check_eq("t2_pass", 64'(chk_pass_a), 64'd0);
        check_eq("t2_fail_word", 64'(fail_word_a), 64'd3);
        check_eq("t2_fail_count", 64'(fail_count_a), 64'd1);
        check_eq("t2_fail_word_b", 64'(fail_word_b), 64'd3);
        exp2 = mix_round(bad);
        send_vec(exp2, 1'b0);
        drain();
        check_eq("resync1_pass", 64'(chk_pass_a), 64'd1);
        check_eq("resync0_pass", 64'(chk_pass_b), 64'd0);

        // Chain of 20 rounds from zero with in_valid held high
        pulse_clr();
        v = '0;
        chain_on = 1'b1;
        chain_prev = -1;
        c0 = chk_cnt;
        for (int k = 0; k < 20; k++) begin
            send_vec(v, 1'b1);
            v = mix_round(v);
        end
        in_valid = 1'b0;
        drain();
        chain_on = 1'b0;
        check_eq("chain_pulses", 64'(chk_cnt - c0), 64'd19);
        check_eq("chain_pass_a", 64'(pass_count_a), 64'd19);
        check_eq("chain_fail_a", 64'(fail_count_a), 64'd0);
        check_eq("chain_pass_b", 64'(pass_count_b), 64'd3);

        // clr in the same cycle as an accept in WAIT
        n = 0;
        while (!in_ready_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait_ready", 64'(in_ready_a), 64'd1);
        clr = 1'b1; in_valid = 1'b1; in_data = exp1;
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        c0 = chk_cnt;
        repeat (3) @(negedge clk);
        check_eq("clracc_no_pulse", 64'(chk_cnt - c0), 64'd0);
        check_eq("clracc_pass_count", 64'(pass_count_a), 64'd0);
        send_vec(seed0, 1'b0);
        send_vec(exp1, 1'b0);
        drain();
        check_eq("clracc_reseed", 64'(pass_count_a), 64'd1);

        // Saturation of the 2-bit fail counter
        pulse_clr();
        send_vec(seed0, 1'b0);
        f = exp1;
        for (int k = 0; k < 5; k++) begin
            g = f;
            g[5][3] = ~g[5][3];
            send_vec(g, 1'b0);
            f = mix_round(g);
        end
        drain();
        check_eq("sat_fail_b", 64'(fail_count_b), 64'd3);
        check_eq("sat_pass_b", 64'(pass_count_b), 64'd0);
        check_eq("sat_fail_a", 64'(fail_count_a), 64'd5);
        check_eq("sat_fail_word_a", 64'(fail_word_a), 64'd5);

        // Asynchronous reset in the middle of COMPUTE
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_in_ready", 64'(in_ready_a), 64'd1);
        check_eq("arst_chk_valid", 64'(chk_valid_a), 64'd0);
        check_eq("arst_fail_word", 64'(fail_word_a), 64'd0);
        check_eq("arst_fail_count", 64'(fail_count_a), 64'd0);
        check_eq("arst_fail_count_b", 64'(fail_count_b), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_vec(seed0, 1'b0);
        send_vec(exp1, 1'b0);
        drain();
        check_eq("arst_reseed_pass", 64'(chk_pass_a), 64'd1);
        check_eq("arst_reseed_count", 64'(pass_count_a), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mix_round_checker.md
# mix_round_checker

Stream-side checker for the 8×32-bit mixing round used by the state-mixing datapath. A producer emits successive 8-word state vectors. This block accepts the first vector as a seed and recomputes one full round serially, one word update per clock. It then compares its result against the next received vector and reports pass/fail, a failing word index and saturating counters. It sits on the consumer end of the producer's valid/ready state stream.

## Interface
- RESYNC, 1: 1 = after each compare, the reloaded working state is the observed vector; 0 = it is the computed vector.
- CNT_W, 16: width of pass/fail counters.
- clk  in  1  Rising-edge clock; the only clock.
- rst_n  in  1  Reset, asynchronous, active-low.
- clr  in  1  Synchronous soft clear: go to IDLE and zero the counters; overrides every other input.
- in_valid  in  1  Producer has a vector on in_data.
- in_ready  out  1  Block can accept a vector.
- in_data  in  256  Word i is bits [32i+31:32i], i = 0..7.
- chk_valid  out  1  One-cycle pulse: a compare result is valid.
- chk_pass  out  1  Result of that compare; held until the next chk_valid.
- fail_word  out  3  Lowest word index that differed; 0 on pass.
- pass_count  out  CNT_W  Passing compares; saturates at all-ones.
- fail_count  out  CNT_W  Failing compares; saturates at all-ones.

## Operation
- Round definition. All arithmetic is 32-bit modulo 2^32. Shifts are logical. Indices are mod 8.
- 16 phases run in the order A B C D E F G H A B C D E F G H.
- Within a phase, i runs 0..7. Each update uses values already updated earlier in the same phase (in-place, sequential).
- A: o[i] += i.
- B: o[i] += o[i-1].
- C: o[i] = o[i] + o[i+1] - o[i+5].
- D: o[i] ^= o[i+3] << 16.
- E: o[i] = o[i] - (o[i+2] >> 17) + (o[i+4] >> 12).
- F: o[i] = o[i] + o[i-1] - o[i-2].
- G: o[i] = o[i]*M1[i] + C1[i].
  - M1 = 2,3,5,7,11,13,17,19.
  - C1 = 3,5,7,11,13,17,19,23.
- H: o[i] = o[i]*M2[i] + C2[i].
  - M2 = 2,3,3,3,5,13,35,87.
  - C2 = 0,1,8,27,64,125,216,343.
- Datapath: one word update per cycle, so one round is 128 cycles.
  - Step counter step[6:0]: phase = step[6:3] (phase mod 8 selects A..H), i = step[2:0].
  - Products keep the low 32 bits only.
- States:
  - IDLE: in_ready=1. On accept, load o ← in_data and go to COMPUTE with step=0.
  - COMPUTE: in_ready=0. Update o[i] once per cycle. At step=127, perform the last update, then go to WAIT.
  - WAIT: in_ready=1. On accept, compare in_data with o word by word.
    - Register chk_pass (1 if all words equal) and fail_word (lowest differing index).
    - Increment the matching counter, saturating.
    - Load o ← in_data if RESYNC=1; otherwise o keeps the computed value.
    - Go to COMPUTE with step=0.
- in_data is sampled only on the accept cycle (in_valid & in_ready). in_valid while in_ready=0 is ignored and leaves no side effect.
- clr in any state: next state IDLE, step=0, counters=0, chk_valid=0. chk_pass, fail_word and o are left unchanged.

## Timing
- Reset values: state IDLE, in_ready=1, chk_valid=0, chk_pass=0, fail_word=0, pass_count=0, fail_count=0, step=0, o all words 0.
- Seed accepted at cycle t: COMPUTE occupies cycles t+1..t+128; in_ready rises at t+129.
- Observed vector accepted at cycle u: chk_valid=1 in cycle u+1 only, with chk_pass, fail_word and the counters already updated in that cycle. COMPUTE occupies u+1..u+128; in_ready=1 again at u+129.
- Back-to-back producer: throughput is one vector per 129 cycles.
- in_ready is a registered state decode with no combinational path from in_valid.
- rst_n asserted mid-COMPUTE or mid-WAIT: all outputs take their reset values immediately (asynchronously). The first accept after release is treated as a seed.
- Counters at all-ones stay at all-ones; the other counter keeps counting.
- clr and an accept in the same cycle: clr wins and the vector is dropped.

## Test plan
- Reset: hold rst_n=0, then release.
  - Required: in_ready=1, chk_valid=0, both counters 0.
  - Assert rst_n=0 asynchronously mid-COMPUTE: outputs return to reset values before the next clk edge.
- Seed {0,1,2,3,4,5,6,7}, then feed the software-model round output.
  - Required: chk_valid pulse exactly 129 cycles after the seed accept (at cycle t+129 with the producer waiting), chk_pass=1, fail_word=0, pass_count=1.
- Same seed, next vector = model output with bit 0 of word 3 flipped.
  - Required: chk_pass=0, fail_word=3, fail_count=1.
  - Run the following round with RESYNC=1 and again with RESYNC=0, checking each against the model.
- Chain of 20 model-generated rounds from seed all zeros, with in_valid held high throughout.
  - Required: 19 chk_valid pulses spaced 129 cycles apart, pass_count=19, in_ready=0 during every COMPUTE window.
- Assert clr during COMPUTE and again in the same cycle as an accept.
  - Required: state IDLE, counters 0, no chk_valid pulse; the next accepted vector is treated as a seed.
- Saturation: with CNT_W=2, feed 5 failing compares.
  - Required: fail_count sticks at 3, pass_count=0.
